// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO sequencing controller.
// Contents: HI/LO op-code encoding, controller state encoding, default
// latencies, result-select codes and small op-classification helpers.
package hilo_pkg;

  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMfhi  = 4'd5,
    OpMflo  = 4'd6,
    OpMthi  = 4'd7,
    OpMtlo  = 4'd8
  } hilo_op_e;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } hilo_state_e;

  localparam int unsigned DefMultLat = 5;
  localparam int unsigned DefDivLat  = 10;
  localparam int unsigned DefCntW    = 4;

  localparam logic [1:0] RdNone = 2'd0;
  localparam logic [1:0] RdHi   = 2'd1;
  localparam logic [1:0] RdLo   = 2'd2;

  // Multi-cycle operations that occupy the arithmetic unit.
  function automatic logic is_long_op(logic [3:0] op);
    return (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
  endfunction

  function automatic logic is_div_op(logic [3:0] op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

  // NONE and codes above MTLO are not HI/LO work.
  function automatic logic is_valid_op(logic [3:0] op);
    return (op != OpNone) && (op <= OpMtlo);
  endfunction

endpackage

// File: rtl/hilo_lat_counter.sv
// hilo_lat_counter: loadable latency down-counter for the HI/LO sequencer.
// Ports:
//   i_clk       clock, rising edge
//   i_reset     asynchronous active-low reset (count -> 0)
//   i_clr       synchronous clear (highest priority)
//   i_load      load i_load_val at next edge
//   i_load_val  latency to load
//   i_hold      freeze count this cycle
//   o_last      count == 1 (final cycle of the operation)
module hilo_lat_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_hold,
  output logic             o_last
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_d;

  always_comb begin
    w_count_d = r_count;
    if (i_clr) begin
      w_count_d = '0;
    end else if (i_load) begin
      w_count_d = i_load_val;
    end else if (!i_hold && (r_count != '0)) begin
      // Saturates at zero so an idle counter never wraps.
      w_count_d = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

  assign o_last = (r_count == CNT_W'(1));

endmodule

// File: rtl/hilo_seq_ctrl.sv
// hilo_seq_ctrl: sequencing controller for the E-stage multiply/divide HI/LO unit.
// Accepts HI/LO-class ops over valid/ready, launches mult/div, counts their
// latency, issues the commit pulse and stalls the pipeline while occupied.
// Optional macro HILO_ABORT_EN: when defined, req in RUN aborts the operation
// (no commit); when undefined, req in RUN freezes it until req falls.
// Ports:
//   i_clk       clock, rising edge
//   i_reset     asynchronous active-low reset
//   i_req       exception/interrupt request; freezes the controller
//   i_op_valid  E stage presents a HI/LO-class instruction
//   i_op_code   HI/LO op code (hilo_pkg encoding)
//   o_op_ready  controller can accept an op this cycle
//   o_stall     valid HI/LO op presented but not ready
//   o_md_start  launch pulse to the arithmetic unit (on accept)
//   o_md_op     op held for the unit, accept through commit
//   o_commit    staged HI/LO written at end of this cycle
//   o_hi_we     mthi write enable (on accept)
//   o_lo_we     mtlo write enable (on accept)
//   o_rd_sel    result select: 0 none, 1 HI, 2 LO
//   o_busy      long operation in flight
module hilo_seq_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned MULT_LAT = DefMultLat,
  parameter int unsigned DIV_LAT  = DefDivLat,
  parameter int unsigned CNT_W    = DefCntW
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req,
  input  logic       i_op_valid,
  input  logic [3:0] i_op_code,
  output logic       o_op_ready,
  output logic       o_stall,
  output logic       o_md_start,
  output logic [3:0] o_md_op,
  output logic       o_commit,
  output logic       o_hi_we,
  output logic       o_lo_we,
  output logic [1:0] o_rd_sel,
  output logic       o_busy
);

  hilo_state_e      r_state;
  hilo_state_e      w_state_d;
  logic [3:0]       r_md_op;
  logic [3:0]       w_md_op_d;
  logic             w_ready;
  logic             w_valid_op;
  logic             w_accept;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_hold;
  logic             w_clr;
  logic             w_last;

  assign w_valid_op = is_valid_op(i_op_code);

  // While reset is held the controller reports ready regardless of req, but
  // nothing may be accepted until reset is released.
  assign w_ready  = (r_state == StIdle) & (!i_req | !i_reset);
  assign w_accept = i_op_valid & w_valid_op & w_ready & i_reset;

  assign o_op_ready = w_ready;
  assign o_stall    = i_op_valid & w_valid_op & !w_ready;
  assign o_busy     = (r_state == StRun);

  // The launching op is visible to the unit in the accept cycle itself.
  assign o_md_op = o_md_start ? i_op_code : r_md_op;

  always_comb begin
    w_state_d  = r_state;
    w_md_op_d  = r_md_op;
    w_load     = 1'b0;
    w_load_val = '0;
    w_hold     = 1'b1;
    w_clr      = 1'b0;
    o_md_start = 1'b0;
    o_commit   = 1'b0;
    o_hi_we    = 1'b0;
    o_lo_we    = 1'b0;
    o_rd_sel   = RdNone;

    case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (is_long_op(i_op_code)) begin
            o_md_start = 1'b1;
            w_md_op_d  = i_op_code;
            w_load     = 1'b1;
            w_load_val = is_div_op(i_op_code) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            w_state_d  = StRun;
          end else begin
            case (i_op_code)
              OpMthi:  o_hi_we  = 1'b1;
              OpMtlo:  o_lo_we  = 1'b1;
              OpMfhi:  o_rd_sel = RdHi;
              OpMflo:  o_rd_sel = RdLo;
              default: ;
            endcase
          end
        end
      end

      StRun: begin
        if (i_req) begin
`ifdef HILO_ABORT_EN
          w_clr     = 1'b1;
          w_md_op_d = OpNone;
          w_state_d = StIdle;
`else
          // Freeze: counter held, state and md_op unchanged.
          w_hold = 1'b1;
`endif
        end else begin
          w_hold = 1'b0;
          if (w_last) begin
            o_commit  = 1'b1;
            w_md_op_d = OpNone;
            w_state_d = StIdle;
          end
        end
      end

      default: begin
        w_clr     = 1'b1;
        w_md_op_d = OpNone;
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= StIdle;
      r_md_op <= OpNone;
    end else begin
      r_state <= w_state_d;
      r_md_op <= w_md_op_d;
    end
  end

  hilo_lat_counter #(
    .CNT_W (CNT_W)
  ) u_lat_counter (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clr      (w_clr),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_hold     (w_hold),
    .o_last     (w_last)
  );

endmodule

// File: doc/hilo_seq_ctrl.md
Name: hilo_seq_ctrl

Overview:
- Sequencing controller for the E-stage multiply/divide HI/LO unit.
- Accepts HI/LO-class instructions from the E stage over a valid/ready handshake and launches long operations (mult/multu/div/divu).
- Owns the latency counter and decides when the unit's staged result is committed into HI/LO.
- Generates the pipeline stall for any HI/LO instruction issued while the unit is occupied, and freezes on exception/interrupt request.

Parameters:
MULT_LAT, 5, cycles from accept of mult/multu to its commit cycle (>=1)
DIV_LAT, 10, cycles from accept of div/divu to its commit cycle (>=1, <=15)
CNT_W, 4, latency counter width; must hold max(MULT_LAT, DIV_LAT)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  1  exception/interrupt request from CP0; freezes controller
op_valid  in  1  E stage presents a HI/LO-class instruction
op_code  in  4  HILO op code (package encoding)
op_ready  out  1  controller can accept op this cycle
stall  out  1  op_valid & !op_ready, to hazard unit
md_start  out  1  one-cycle launch pulse to arithmetic unit (combinational on accept)
md_op  out  4  op code held for the unit; valid from accept through commit
commit  out  1  one-cycle pulse: unit's staged HI/LO written at end of this cycle
hi_we  out  1  mthi write enable (combinational on accept)
lo_we  out  1  mtlo write enable (combinational on accept)
rd_sel  out  2  0 none, 1 HI, 2 LO; result mux select for mfhi/mflo
busy  out  1  long operation in flight (state RUN)

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, count=0, md_op=NONE. All registered outputs read 0 and op_ready=1 while reset is held (it is IDLE and req-independent only during reset).
- States: IDLE, RUN.
- accept = op_valid & op_ready. op_ready = (state==IDLE) & !req.
- IDLE, accept of a long op (MULT, MULTU, DIV, DIVU):
  - md_start=1 in the same cycle.
  - md_op latched; count <= MULT_LAT or DIV_LAT; next state RUN.
- IDLE, accept of a short op:
  - MTHI: hi_we=1 the same cycle.
  - MTLO: lo_we=1 the same cycle.
  - MFHI: rd_sel=1 the same cycle; MFLO: rd_sel=2 the same cycle.
  - State stays IDLE.
- NONE or undefined op_code: never accepted as work. op_ready still reported, no outputs pulse, and stall stays 0.
- RUN, req=0: count decrements each cycle. When count==1, commit=1; next state IDLE, count=0.
- Timing: accept in cycle T gives commit in cycle T+LAT-1+... exactly T+LAT for LAT>=1 (mult: T+5, div: T+10). busy=1 for cycles T+1..T+LAT. First new accept is possible at T+LAT+1.
- RUN, req=1: count, state and md_op hold; no commit.
- Any cycle with req=1: op_ready=0, so no accept and no md_start/hi_we/lo_we.
- Simultaneous events:
  - op_valid during the commit cycle is stalled; it is accepted in the next cycle.
  - mfhi/mflo behind a long op stalls until after commit, so it reads the committed value.
- md_op returns to NONE the cycle after commit.
- Reset asserted mid-RUN: immediate return to IDLE; the staged result is never committed.

Optional Feature:
- Macro: HILO_ABORT_EN.
- Defined: req=1 while in RUN aborts the operation. State goes to IDLE and count to 0 at the next edge, commit is never issued, and md_op goes to NONE.
- Undefined: req in RUN freezes as described above, and the operation resumes and commits once req falls.

Decomposition:
- Shared package hilo_pkg (or the common define header):
  - HILO op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
  - Default latencies.
  - State encoding IDLE=0, RUN=1.
- One natural sub-module, hilo_lat_counter:
  - Loadable down-counter with hold input.
  - Outputs last = (count==1).

Test Plan:
- MULT accepted at cycle 10, req=0 -> md_start=1 @10; busy=1 @11..15; commit=1 @15 only; op_ready=1 @16.
- DIV at cycle 0 then MFLO held valid from cycle 1 -> stall=1 @1..10; MFLO accepted @11 with rd_sel=2; commit @10.
- MTHI in IDLE -> hi_we=1 same cycle, state stays IDLE; MTHI during RUN -> stall=1, hi_we=0 until IDLE.
- MULTU at cycle 0, req=1 @2..4 -> without HILO_ABORT_EN commit @8; with HILO_ABORT_EN IDLE @3 and no commit ever.
- DIVU at cycle 0, reset=0 @4 (async, mid-cycle) -> busy=0 and state IDLE immediately; no commit after release.
- req=1 in IDLE with op_valid=1 MULT -> op_ready=0, md_start=0, stall=1; accept on first cycle req=0.
